// File: rtl/spi_master_pkg.sv
// Shared types and default constants for the SPI master controller.
package spi_master_pkg;

  localparam int unsigned DATA_W_DEF   = 8;
  localparam int unsigned HALF_DIV_DEF = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    SHIFT = 3'd2,
    TRAIL = 3'd3,
    GAP   = 3'd4
  } spi_state_e;

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Local control bus of the SPI master: transfer request, status and received word.
interface spi_master_ctrl_if #(
  parameter int unsigned DATA_W = 8
);
  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;

  // Host side issues requests and observes status.
  modport master (output start, output tx_data, input busy, input done, input rx_data);
  // Controller side accepts requests and reports status.
  modport slave  (input start, input tx_data, output busy, output done, output rx_data);
endinterface

// File: rtl/spi_clk_div.sv
// Half-period counter: one-cycle tick_c every HALF_DIV cycles while en is high.
module spi_clk_div #(
  parameter int unsigned HALF_DIV = 2
) (
  input  logic clk,
  input  logic rst_b,
  input  logic en,
  output logic tick_c
);
  localparam int unsigned CNT_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count while enabled, wrap at the end of each half period, clear when disabled.
  always_comb begin
    cnt_d = '0;
    if (en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick_c = en && (cnt_q == CNT_MAX);
endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: one DATA_W-bit full-duplex frame per accepted start.
// Optional macro SPI_MASTER_LSB_FIRST_EN selects LSB-first bit order in both directions.
module spi_master_ctrl
  import spi_master_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned HALF_DIV = HALF_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst_b,
  spi_master_ctrl_if.slave bus,
  output logic             cs_b,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso
);
  localparam int unsigned BC_W = $clog2(DATA_W + 1);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);
  localparam logic [BC_W-1:0] ALL_BITS = BC_W'(DATA_W);

  spi_state_e        state_q, state_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic              cs_b_q, cs_b_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              tick_c;
  logic              div_en_c;
  logic              first_bit_c;
  logic              next_bit_c;
  logic [DATA_W-1:0] tx_shift_c;
  logic [DATA_W-1:0] rx_shift_c;

  // Bit ordering of the shift registers.
`ifdef SPI_MASTER_LSB_FIRST_EN
  assign first_bit_c = bus.tx_data[0];
  assign next_bit_c  = tx_sr_q[1];
  assign tx_shift_c  = tx_sr_q >> 1;
  assign rx_shift_c  = {miso, rx_sr_q[DATA_W-1:1]};
`else
  assign first_bit_c = bus.tx_data[DATA_W-1];
  assign next_bit_c  = tx_sr_q[DATA_W-2];
  assign tx_shift_c  = tx_sr_q << 1;
  assign rx_shift_c  = {rx_sr_q[DATA_W-2:0], miso};
`endif

  assign div_en_c = (state_q != IDLE);

  spi_clk_div #(.HALF_DIV(HALF_DIV)) u_clk_div (
    .clk    (clk),
    .rst_b  (rst_b),
    .en     (div_en_c),
    .tick_c (tick_c)
  );

  // Frame sequencing: next state and registered pin/status values.
  always_comb begin
    state_d   = state_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    bit_cnt_d = bit_cnt_q;
    cs_b_d    = cs_b_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          tx_sr_d   = bus.tx_data;
          mosi_d    = first_bit_c;
          cs_b_d    = 1'b0;
          busy_d    = 1'b1;
          bit_cnt_d = '0;
          state_d   = LEAD;
        end
      end
      LEAD: begin
        if (tick_c) begin
          sclk_d  = 1'b1;
          rx_sr_d = rx_shift_c;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (tick_c) begin
          if (sclk_q) begin
            // Falling edge: advance to the next bit unless this was the last one.
            sclk_d    = 1'b0;
            bit_cnt_d = bit_cnt_q + BC_W'(1);
            if (bit_cnt_q != LAST_BIT) begin
              tx_sr_d = tx_shift_c;
              mosi_d  = next_bit_c;
            end
          end else if (bit_cnt_q == ALL_BITS) begin
            // Last bit has had its full low half period.
            state_d = TRAIL;
          end else begin
            sclk_d  = 1'b1;
            rx_sr_d = rx_shift_c;
          end
        end
      end
      TRAIL: begin
        if (tick_c) begin
          cs_b_d    = 1'b1;
          done_d    = 1'b1;
          rx_data_d = rx_sr_q;
          state_d   = GAP;
        end
      end
      GAP: begin
        if (tick_c) begin
          busy_d  = 1'b0;
          mosi_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= IDLE;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      bit_cnt_q <= '0;
      cs_b_q    <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      bit_cnt_q <= bit_cnt_d;
      cs_b_q    <= cs_b_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign cs_b        = cs_b_q;
  assign sclk        = sclk_q;
  assign mosi        = mosi_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl (DATA_W=8, HALF_DIV=2).
module tb_spi_master_ctrl;

  typedef struct {
    logic [7:0]  rx;
    logic [7:0]  seq;
    int unsigned t0;
  } exp_t;

  exp_t exp_q[$];

  logic clk = 1'b0;
  logic rst_b;
  logic cs_b, sclk, mosi, miso;
  logic loop, miso_fix;
  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;

  spi_master_ctrl_if #(.DATA_W(8)) bus ();

  spi_master_ctrl #(.DATA_W(8), .HALF_DIV(2)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus),
    .cs_b  (cs_b),
    .sclk  (sclk),
    .mosi  (mosi),
    .miso  (miso)
  );

  assign miso = loop ? mosi : miso_fix;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  // Order in which tx bits appear on mosi, captured MSB-first by the monitor.
  function automatic logic [7:0] wire_order(logic [7:0] tx);
    logic [7:0] r;
`ifdef SPI_MASTER_LSB_FIRST_EN
    for (int i = 0; i < 8; i++) r[i] = tx[7-i];
`else
    r = tx;
`endif
    return r;
  endfunction

  // Monitor: counts sclk edges and cs_b low time, checks each done against the queue.
  int unsigned rises = 0, cs_low = 0;
  logic [7:0]  seq_cap = 8'h00;
  logic        sclk_prev = 1'b0;
  exp_t        e;
  always @(negedge clk) begin
    if (!rst_b) begin
      rises = 0; cs_low = 0; seq_cap = 8'h00; sclk_prev = 1'b0;
    end else begin
      if (sclk && !sclk_prev) begin
        rises++;
        seq_cap = {seq_cap[6:0], mosi};
      end
      sclk_prev = sclk;
      if (!cs_b) cs_low++;
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rx_data", 32'(bus.rx_data), 32'(e.rx));
          chk("mosi_seq", 32'(seq_cap), 32'(e.seq));
          chk("sclk_rises", rises, 32'd8);
          chk("cs_low_cycles", cs_low, 32'd36);
          chk("done_latency", cyc - e.t0, 32'd37);
          chk("cs_b_at_done", 32'(cs_b), 32'd1);
          chk("busy_at_done", 32'(bus.busy), 32'd1);
        end
        rises = 0; cs_low = 0;
      end
    end
  end

  task automatic start_frame(input logic [7:0] tx, input logic lb, input logic mf,
                             input logic [7:0] exp_rx);
    exp_t x;
    loop = lb; miso_fix = mf;
    @(negedge clk);
    bus.start = 1'b1; bus.tx_data = tx;
    x.rx = exp_rx; x.seq = wire_order(tx); x.t0 = cyc;
    exp_q.push_back(x);
    @(negedge clk);
    bus.start = 1'b0; bus.tx_data = ~tx;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.done) begin seen = 1'b1; break; end
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.busy) begin seen = 1'b1; break; end
    end
    if (!seen) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_idle_pins(string tag);
    chk({tag, "_cs_b"}, 32'(cs_b), 32'd1);
    chk({tag, "_sclk"}, 32'(sclk), 32'd0);
    chk({tag, "_mosi"}, 32'(mosi), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic p;
    rst_b = 1'b0; loop = 1'b0; miso_fix = 1'b0;
    bus.start = 1'b0; bus.tx_data = 8'h00;
    repeat (3) @(negedge clk);
    check_idle_pins("rst");
    chk("rst_rx_data", 32'(bus.rx_data), 32'h00);
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_pins("post_rst");
    chk("post_rst_rx_data", 32'(bus.rx_data), 32'h00);

    // Loopback and fixed-miso frames.
    start_frame(8'hA5, 1'b1, 1'b0, 8'hA5); wait_done(); wait_idle();
    start_frame(8'h3C, 1'b0, 1'b0, 8'h00); wait_done(); wait_idle();
    start_frame(8'h3C, 1'b0, 1'b1, 8'hFF); wait_done(); wait_idle();

    // start during a frame is ignored; start in the cycle busy falls is ignored.
    start_frame(8'h96, 1'b1, 1'b0, 8'h96);
    repeat (10) @(negedge clk);
    bus.start = 1'b1; bus.tx_data = 8'hFF;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    @(negedge clk);
    chk("busy_gap_end", 32'(bus.busy), 32'd1);
    bus.start = 1'b1; bus.tx_data = 8'hFF;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_gap", 32'(bus.busy), 32'd0);
    repeat (10) @(negedge clk);
    check_idle_pins("late_start_ignored");
    start_frame(8'hC3, 1'b1, 1'b0, 8'hC3); wait_done(); wait_idle();

    // Mid-frame reset after the third sclk rising edge.
    start_frame(8'h77, 1'b1, 1'b0, 8'h77);
    r = 0; p = 1'b0;
    for (int i = 0; i < 100 && r < 3; i++) begin
      @(negedge clk);
      if (sclk && !p) r++;
      p = sclk;
    end
    chk("third_rise_seen", r, 32'd3);
    rst_b = 1'b0;
    void'(exp_q.pop_front());
    #1;
    check_idle_pins("mid_rst");
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    repeat (50) @(negedge clk);
    check_idle_pins("after_abort");
    start_frame(8'h5A, 1'b1, 1'b0, 8'h5A); wait_done(); wait_idle();

    // Single set bit exposes the bit order on the wire.
    start_frame(8'h01, 1'b1, 1'b0, 8'h01); wait_done(); wait_idle();

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- Single-channel SPI bus master. Operates in mode 0 (CPOL=0, CPHA=0).
- Sits between a local register/control interface and the chip-level SPI pins `cs_b`, `sclk`, `mosi` and `miso`.
- On a `start` pulse it asserts `cs_b`, shifts one DATA_W-bit word out on `mosi`, captures DATA_W bits from `miso`, then releases `cs_b` and pulses `done`.

Parameters:
- DATA_W, 8: transfer word length in bits. Legal range is ≥2.
- HALF_DIV, 2: number of `clk` cycles per `sclk` half-period. Legal range is ≥1.

Ports:
- `clk` input 1: system clock. All state changes on its rising edge.
- `rst_b` input 1: asynchronous active-low reset.
- `start` input 1: one-cycle transfer request. Sampled only while `busy`=0.
- `tx_data` input DATA_W: word to transmit. Latched on an accepted `start`.
- `busy` output 1: high from the cycle after an accepted `start` until the end of the inter-frame gap.
- `done` output 1: one-cycle pulse at end of frame.
- `rx_data` output DATA_W: last received word. Updated in the same cycle as the `done` pulse.
- `cs_b` output 1: chip select, active low.
- `sclk` output 1: serial clock. Idle level is low.
- `mosi` output 1: serial data out.
- `miso` input 1: serial data in.

Behaviour:
- Reset (`rst_b`=0, asynchronous):
  - `cs_b`=1, `sclk`=0, `mosi`=0, `busy`=0, `done`=0, `rx_data`=0.
  - State goes to IDLE; counters are cleared.
  - Reset asserted mid-frame aborts the frame immediately, with no `done` pulse.
- States are IDLE, LEAD, SHIFT, TRAIL and GAP.
- IDLE:
  - When `start`=1: latch `tx_data` into the TX shift register.
  - On the next edge: `cs_b`←0, `mosi`←MSB, `busy`←1, go to LEAD.
- LEAD:
  - `sclk` stays 0 for HALF_DIV cycles, then `sclk`←1. Go to SHIFT.
- SHIFT, per bit:
  - On the edge that drives `sclk` high, sample `miso` into the RX shift register, MSB first.
  - After HALF_DIV cycles high, `sclk`←0 and `mosi`←next bit.
  - Exactly DATA_W rising edges per frame.
  - After the last falling edge `mosi` holds the last bit; go to TRAIL.
- TRAIL:
  - `cs_b` stays low for HALF_DIV cycles, then `cs_b`←1.
  - `done`←1 for one cycle and `rx_data`←RX shift register.
  - Go to GAP.
- GAP:
  - `cs_b` high and `busy`=1 for HALF_DIV cycles.
  - Then `busy`←0 and `mosi`←0; go to IDLE.
- Latency: with `start` accepted at cycle 0, `cs_b` falls at cycle 1 and `done` pulses at cycle 1+2·HALF_DIV·(DATA_W+1). With the default parameters that is cycle 37.
- `start` while `busy`=1 is ignored; no queuing.
- `tx_data` changes after acceptance have no effect on the current frame.
- `start` in the same cycle that `busy` falls is not accepted; acceptance requires `busy`=0 at the sampling edge.
- All outputs are registered, so `sclk`, `cs_b` and `mosi` are glitch-free.

Optional Feature:
- Macro: SPI_MASTER_LSB_FIRST_EN.
- When defined: bits are transmitted LSB first and received `miso` bits fill `rx_data` from bit 0 upward.
- When undefined (default): MSB first in both directions.
- Timing is identical in both modes.

Decomposition:
- Package spi_master_pkg contains:
  - the state enum `spi_state_e` (IDLE, LEAD, SHIFT, TRAIL, GAP);
  - default constants DATA_W_DEF=8 and HALF_DIV_DEF=2.
- One natural sub-module, spi_clk_div: half-period counter producing a one-cycle `tick` every HALF_DIV cycles while enabled, and cleared when disabled.

Test Plan:
- Reset: hold `rst_b`=0 → `cs_b`=1, `sclk`=0, `mosi`=0, `busy`=0, `done`=0, `rx_data`=0x00. Release with `miso`=0 → outputs unchanged.
- Loopback (`miso` tied to `mosi`): `start` with `tx_data`=0xA5 → 8 `sclk` rising edges, `mosi` sequence 1,0,1,0,0,1,0,1, `done` at cycle 37, `rx_data`=0xA5.
- Fixed `miso`: `miso`=0 with `tx_data`=0x3C → `rx_data`=0x00. `miso`=1 → `rx_data`=0xFF. `cs_b` low exactly 36 cycles.
- Busy rejection: second `start` with `tx_data`=0xFF during a frame → ignored, no extra `sclk` edges. A new `start` after `busy`=0 → a second frame is accepted.
- Mid-frame reset: `rst_b` pulsed low after the 3rd `sclk` rising edge → `cs_b`=1 and `sclk`=0 immediately, no `done`. A next frame with 0x5A loopback gives `rx_data`=0x5A.
- With SPI_MASTER_LSB_FIRST_EN: `tx_data`=0x01 → `mosi` high only during the first bit, loopback `rx_data`=0x01.
